// File: rtl/hgcal_pkg.sv
// hgcal_pkg: shared frame geometry, quantization thresholds and packer state type.
package hgcal_pkg;
  localparam int N_IN = 48;
  localparam int IN_W = 16;
  localparam int Q_W = 2;
  localparam logic [15:0] THR0 = 16'd64;
  localparam logic [15:0] THR1 = 16'd256;
  localparam logic [15:0] THR2 = 16'd1024;
  typedef enum logic {COLLECT, FULL} state_t;
endpackage

// File: rtl/input_quantizer_packer_if.sv
// input_quantizer_packer_if: raw sample stream in, packed quantized frame out.
interface input_quantizer_packer_if #(
  parameter int N_IN = hgcal_pkg::N_IN,
  parameter int IN_W = hgcal_pkg::IN_W,
  parameter int Q_W = hgcal_pkg::Q_W
);
  logic [IN_W-1:0] s_data;
  logic s_valid;
  logic s_last;
  logic s_ready;
  logic [N_IN*Q_W-1:0] m_data;
  logic m_valid;
  logic m_ready;
  logic frame_err;
  modport slave (
    input s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, frame_err
  );
  modport master (
    output s_data, s_valid, s_last, m_ready,
    input s_ready, m_data, m_valid, frame_err
  );
endinterface

// File: rtl/quant_thresh.sv
// quant_thresh: unsigned three-threshold quantizer of one raw cell sample.
module quant_thresh #(
  parameter int IN_W = hgcal_pkg::IN_W,
  parameter int Q_W = hgcal_pkg::Q_W,
  parameter logic [IN_W-1:0] THR0 = IN_W'(hgcal_pkg::THR0),
  parameter logic [IN_W-1:0] THR1 = IN_W'(hgcal_pkg::THR1),
  parameter logic [IN_W-1:0] THR2 = IN_W'(hgcal_pkg::THR2)
) (
  input  logic [IN_W-1:0] i_x,
  output logic [Q_W-1:0]  o_q
);
  assign o_q = (i_x >= THR2) ? Q_W'(3) : (i_x >= THR1) ? Q_W'(2) : (i_x >= THR0) ? Q_W'(1) : Q_W'(0);
endmodule

// File: rtl/input_quantizer_packer.sv
// input_quantizer_packer: quantizes a stream of cell samples and packs N_IN of them
// into one frame held until the downstream consumer accepts it.
module input_quantizer_packer import hgcal_pkg::*; #(
  parameter int N_IN = hgcal_pkg::N_IN,
  parameter int IN_W = hgcal_pkg::IN_W,
  parameter int Q_W = hgcal_pkg::Q_W,
  parameter logic [IN_W-1:0] THR0 = IN_W'(hgcal_pkg::THR0),
  parameter logic [IN_W-1:0] THR1 = IN_W'(hgcal_pkg::THR1),
  parameter logic [IN_W-1:0] THR2 = IN_W'(hgcal_pkg::THR2)
) (
  input logic clk,
  input logic rst,
  input_quantizer_packer_if.slave bus
);
  localparam int IDX_W = $clog2(N_IN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);
  logic [Q_W-1:0] w_q;
  logic w_s_xfer, w_m_xfer;
  state_t r_state;
  logic [IDX_W-1:0] r_idx;
  logic [N_IN*Q_W-1:0] r_data;
  logic r_valid, r_err;
  quant_thresh #(.IN_W(IN_W), .Q_W(Q_W), .THR0(THR0), .THR1(THR1), .THR2(THR2)) u_qt (
    .i_x(bus.s_data),
    .o_q(w_q)
  );
  assign bus.s_ready = !rst && (r_state == COLLECT || bus.m_ready);
  assign w_s_xfer = bus.s_valid && bus.s_ready;
  assign w_m_xfer = r_valid && bus.m_ready;
  assign bus.m_data = r_data;
  assign bus.m_valid = r_valid;
  assign bus.frame_err = r_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
      r_idx <= '0;
      r_data <= '0;
      r_valid <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_state == FULL) begin
        // leaving FULL clears the frame; a concurrent sample opens the next one
        if (w_m_xfer) begin
          r_state <= COLLECT;
          r_valid <= 1'b0;
          r_data <= '0;
          r_idx <= '0;
          r_err <= w_s_xfer && bus.s_last;
          if (w_s_xfer && !bus.s_last) begin
            r_data[Q_W-1:0] <= w_q;
            r_idx <= IDX_W'(1);
          end
        end
      end else if (w_s_xfer) begin
        if (r_idx == LAST_IDX) begin
          r_data[r_idx*Q_W +: Q_W] <= w_q;
          r_state <= FULL;
          r_valid <= 1'b1;
          r_idx <= '0;
          r_err <= !bus.s_last;
        end else if (bus.s_last) begin
          r_data <= '0;
          r_idx <= '0;
          r_err <= 1'b1;
        end else begin
          r_data[r_idx*Q_W +: Q_W] <= w_q;
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_input_quantizer_packer.sv
// tb_input_quantizer_packer: directed scenarios plus random traffic checked every cycle
// against a sample-level frame model.
module tb_input_quantizer_packer;
  localparam int N = 48;
  localparam int W = 96;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  input_quantizer_packer_if u_if();
  input_quantizer_packer u_dut (.clk(clk), .rst(rst), .bus(u_if.slave));
  int n_total = 0;
  int n_bad = 0;
  bit m_full = 1'b0;
  bit m_err = 1'b0;
  int m_cnt = 0;
  logic [W-1:0] m_part = '0;
  logic [W-1:0] m_frame = '0;
  task automatic check(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int qref(int x);
    if (x >= 1024) return 3;
    if (x >= 256) return 2;
    if (x >= 64) return 1;
    return 0;
  endfunction
  function automatic bit exp_ready();
    return !rst && (!m_full || u_if.m_ready);
  endfunction
  function automatic logic [15:0] rnd();
    logic [15:0] tbl [12] = '{16'd0, 16'd63, 16'd64, 16'd65, 16'd255, 16'd256,
                              16'd257, 16'd1023, 16'd1024, 16'd1025, 16'hFFFF, 16'd0};
    int k;
    k = $urandom_range(0, 11);
    return (k == 11) ? 16'($urandom) : tbl[k];
  endfunction
  initial begin
    bit sx, mx;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_full = 1'b0;
        m_cnt = 0;
        m_part = '0;
        m_err = 1'b0;
      end else begin
        sx = u_if.s_valid && exp_ready();
        mx = m_full && u_if.m_ready;
        m_err = 1'b0;
        if (mx) m_full = 1'b0;
        if (sx) begin
          m_part = m_part | (W'(qref(int'(u_if.s_data))) << (2 * m_cnt));
          if (m_cnt == N - 1) begin
            m_frame = m_part;
            m_full = 1'b1;
            m_err = !u_if.s_last;
            m_cnt = 0;
            m_part = '0;
          end else if (u_if.s_last) begin
            m_err = 1'b1;
            m_cnt = 0;
            m_part = '0;
          end else m_cnt++;
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    check("s_ready", W'(u_if.s_ready), W'(exp_ready()));
    check("m_valid", W'(u_if.m_valid), W'(m_full));
    check("m_data", u_if.m_data, m_full ? m_frame : m_part);
    check("frame_err", W'(u_if.frame_err), W'(m_err));
  end
  task automatic drive(bit v, logic [15:0] d, bit l, bit mr);
    u_if.s_valid = v;
    u_if.s_data = d;
    u_if.s_last = l;
    u_if.m_ready = mr;
    @(posedge clk);
    #1;
  endtask
  task automatic send(logic [15:0] d, bit l, bit mr);
    int t;
    bit acc;
    t = 0;
    do begin
      u_if.s_valid = 1'b1;
      u_if.s_data = d;
      u_if.s_last = l;
      u_if.m_ready = mr;
      @(negedge clk);
      acc = u_if.s_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 200);
    u_if.s_valid = 1'b0;
    if (!acc) check("send_timeout", W'(acc), W'(1));
  endtask
  task automatic frame(int n, int last_at, bit mr);
    for (int i = 0; i < n; i++) send(rnd(), i == last_at, mr);
  endtask
  initial begin
    u_if.s_valid = 1'b0;
    u_if.s_data = '0;
    u_if.s_last = 1'b0;
    u_if.m_ready = 1'b1;
    repeat (3) drive(0, 0, 0, 1);
    rst = 1'b0;
    for (int i = 0; i < N; i++) send(16'd1024, i == N - 1, 1);
    @(negedge clk);
    check("all_ones", u_if.m_data, {W{1'b1}});
    check("all_ones_valid", W'(u_if.m_valid), W'(1));
    check("all_ones_err", W'(u_if.frame_err), W'(0));
    drive(0, 0, 0, 1);
    send(16'd63, 0, 0);
    send(16'd64, 0, 0);
    send(16'd255, 0, 0);
    send(16'd256, 0, 0);
    send(16'd1023, 0, 0);
    send(16'd1024, 0, 0);
    for (int i = 6; i < N; i++) send(16'd0, i == N - 1, 0);
    @(negedge clk);
    check("thresh_pack", W'(u_if.m_data[11:0]), W'(12'b11_10_10_01_01_00));
    repeat (5) drive(1, 16'd500, 0, 0);
    check("hold_sready", W'(u_if.s_ready), W'(0));
    check("hold_data", W'(u_if.m_data[11:0]), W'(12'b11_10_10_01_01_00));
    drive(1, 16'd2000, 0, 1);
    @(negedge clk);
    check("swap_valid", W'(u_if.m_valid), W'(0));
    check("swap_idx0", W'(u_if.m_data[1:0]), W'(2'd3));
    frame(N - 1, N - 2, 1);
    drive(0, 0, 0, 1);
    frame(11, 10, 1);
    @(negedge clk);
    check("short_err", W'(u_if.frame_err), W'(1));
    drive(0, 0, 0, 1);
    check("short_err_once", W'(u_if.frame_err), W'(0));
    frame(N, N - 1, 1);
    drive(0, 0, 0, 1);
    frame(N, -1, 1);
    @(negedge clk);
    check("nolast_err", W'(u_if.frame_err), W'(1));
    check("nolast_valid", W'(u_if.m_valid), W'(1));
    drive(0, 0, 0, 1);
    frame(20, -1, 1);
    rst = 1'b1;
    repeat (2) drive(1, 16'd2000, 0, 1);
    rst = 1'b0;
    check("rst_valid", W'(u_if.m_valid), W'(0));
    frame(N, N - 1, 1);
    drive(0, 0, 0, 1);
    for (int c = 0; c < 4000; c++) begin
      bit l;
      l = (m_cnt == N - 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 599) == 0);
      drive($urandom_range(0, 3) != 0, rnd(), l, $urandom_range(0, 9) < 7);
    end
    rst = 1'b0;
    repeat (3) drive(0, 0, 0, 1);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
